// File: rtl/spi_pkg.sv
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types, constants and length clamp for the SPI frame
//                shifter family.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // A zero or oversize length request means "full register width".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_frame_shifter.sv
// ============================================================================
//  Module      : spi_frame_shifter
//  Description : Tick-paced SPI shift register with runtime frame length,
//                selectable bit order and start/busy/done handshake.
//                Optional macro SPI_FRAME_SHIFTER_LOOPBACK_EN adds a loopback
//                input that feeds tx back into the receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_shifter
    import spi_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_TX   = 1'b1,
    parameter int   LEN_W     = $clog2(WIDTH + 1)
) (
    input  logic             CLKB,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [WIDTH-1:0] data_in,
    input  logic             tick,
    input  logic             rx,
`ifdef SPI_FRAME_SHIFTER_LOOPBACK_EN
    input  logic             loopback,
`endif
    output logic             tx,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;

    logic [LEN_W-1:0]   w_len_eff;
    logic [WIDTH-1:0]   w_mask_cur;
    logic [WIDTH-1:0]   w_top_cur;
    logic               w_tx_bit;
    logic               w_rx_bit;
    logic               w_last;

    // Ones in bit positions [l-1:0].
    function automatic logic [WIDTH-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (LEN_W'(i) < l);
        end
        return m;
    endfunction

    assign w_len_eff  = LEN_W'(eff_len(32'(len), WIDTH));
    assign w_mask_cur = len_mask(len_q);
    assign w_top_cur  = w_mask_cur ^ (w_mask_cur >> 1);
    assign w_tx_bit   = (MSB_FIRST != 0) ? |(shreg_q & w_top_cur) : shreg_q[0];
    assign w_last     = (cnt_q == len_q - LEN_W'(1));

`ifdef SPI_FRAME_SHIFTER_LOOPBACK_EN
    assign w_rx_bit = loopback ? w_tx_bit : rx;
`else
    assign w_rx_bit = rx;
`endif

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        data_out_d = data_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d   = w_len_eff;
                    shreg_d = data_in & len_mask(w_len_eff);
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    // Bits at or above L are kept zero so tx always picks bit L-1.
                    if (MSB_FIRST != 0) begin
                        shreg_d = ((shreg_q << 1) | {{(WIDTH-1){1'b0}}, w_rx_bit}) & w_mask_cur;
                    end else begin
                        shreg_d = (shreg_q >> 1) | (w_rx_bit ? w_top_cur : '0);
                    end
                    cnt_d = cnt_q + LEN_W'(1);
                    if (w_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                data_out_d = shreg_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKB) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            data_out_q <= data_out_d;
        end
    end

    assign tx       = (state_q == ST_SHIFT) ? w_tx_bit : IDLE_TX;
    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign data_out = data_out_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_shifter.sv
// ============================================================================
//  Module      : tb_spi_frame_shifter
//  Description : Randomised self-checking bench; one MSB-first and one
//                LSB-first instance share stimulus and are checked against a
//                bit-list reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_frame_shifter;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] data_in;
    logic             tick;
    logic             rx;
    logic             loopback;
    logic             tx_m, tx_l, busy_m, busy_l, done_m, done_l;
    logic [WIDTH-1:0] dout_m, dout_l;
    logic [WIDTH-1:0] exp_m, exp_l;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spi_frame_shifter #(.WIDTH(WIDTH), .MSB_FIRST(1), .IDLE_TX(1'b1)) u_msb (
        .CLKB(clk), .RST(rst), .start(start), .len(len), .data_in(data_in),
        .tick(tick), .rx(rx),
`ifdef SPI_FRAME_SHIFTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .tx(tx_m), .data_out(dout_m), .busy(busy_m), .done(done_m)
    );

    spi_frame_shifter #(.WIDTH(WIDTH), .MSB_FIRST(0), .IDLE_TX(1'b1)) u_lsb (
        .CLKB(clk), .RST(rst), .start(start), .len(len), .data_in(data_in),
        .tick(tick), .rx(rx),
`ifdef SPI_FRAME_SHIFTER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .tx(tx_l), .data_out(dout_l), .busy(busy_l), .done(done_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle();
        check("idle_tx_m", 32'(tx_m), 32'd1);
        check("idle_tx_l", 32'(tx_l), 32'd1);
        check("idle_busy", 32'({busy_m, busy_l}), 32'd0);
        check("idle_done", 32'({done_m, done_l}), 32'd0);
        check("idle_dout_m", 32'(dout_m), 32'(exp_m));
        check("idle_dout_l", 32'(dout_l), 32'(exp_l));
    endtask

    // rw[k] is the rx bit presented on the k-th tick of the frame.
    task automatic run_frame(input int lenv, input logic [WIDTH-1:0] d,
                             input logic [WIDTH-1:0] rw, input bit glitch, input bit lb);
        int L;
        L = ((lenv == 0) || (lenv > WIDTH)) ? WIDTH : lenv;
        start    = 1'b1;
        len      = LEN_W'(lenv);
        data_in  = d;
        tick     = glitch;
        rx       = 1'b0;
        loopback = lb;
        step();
        start = 1'b0;
        tick  = 1'b0;
        for (int k = 0; k < L; k++) begin
            repeat ($urandom_range(0, 2)) begin
                check("gap_busy", 32'({busy_m, busy_l}), 32'd3);
                step();
            end
            check("tx_m", 32'(tx_m), 32'(d[L-1-k]));
            check("tx_l", 32'(tx_l), 32'(d[k]));
            check("shift_busy", 32'({busy_m, busy_l}), 32'd3);
            check("shift_done", 32'({done_m, done_l}), 32'd0);
            tick  = 1'b1;
            rx    = rw[k];
            start = glitch && (k == 3);
            if (glitch && (k == 3)) data_in = ~d;
            step();
            tick  = 1'b0;
            start = 1'b0;
        end
        check("done_m", 32'(done_m), 32'd1);
        check("done_l", 32'(done_l), 32'd1);
        check("done_busy", 32'({busy_m, busy_l}), 32'd0);
        check("done_tx", 32'({tx_m, tx_l}), 32'd3);
        exp_m = '0;
        exp_l = '0;
        for (int k = 0; k < L; k++) begin
            if (lb) begin
                exp_m[k] = d[k];
                exp_l[k] = d[k];
            end else begin
                exp_m[L-1-k] = rw[k];
                exp_l[k]     = rw[k];
            end
        end
        start = glitch;
        step();
        start = 1'b0;
        check_idle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; data_in = '0; tick = 1'b0;
        rx = 1'b0; loopback = 1'b0;
        exp_m = '0; exp_l = '0;
        step();
        step();
        check_idle();
        rst = 1'b0;
        step();

        // Directed: 8-bit frame, rx pattern 3C (palindromic, so order-free).
        run_frame(8, 16'h00A5, 16'h003C, 1'b0, 1'b0);
        check("dir1_dout_m", 32'(dout_m), 32'h003C);
        // Directed: len=0 means 16 bits.
        run_frame(0, 16'h8001, 16'h1234, 1'b0, 1'b0);
        check("dir2_dout_l", 32'(dout_l), 32'h1234);
        // Stray starts mid-frame, with tick at accept, and in DONE.
        run_frame(8, 16'h00C3, 16'h005A, 1'b1, 1'b0);
        // Oversize length clamps to WIDTH.
        run_frame(20, 16'hBEEF, 16'h7E81, 1'b0, 1'b0);

        // Ticks while idle must not disturb anything.
        tick = 1'b1; rx = 1'b1;
        repeat (3) step();
        tick = 1'b0;
        check_idle();

        // Abort mid-frame.
        start = 1'b1; len = 5'd8; data_in = 16'h00FF;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick = 1'b1; rx = 1'b1;
            step();
        end
        tick = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_m = '0; exp_l = '0;
        check_idle();
        step();
        check_idle();
        run_frame(4, 16'h000F, 16'h0000, 1'b0, 1'b0);

`ifdef SPI_FRAME_SHIFTER_LOOPBACK_EN
        run_frame(12, 16'h0ABC, 16'hFFFF, 1'b0, 1'b1);
        check("lb_dout_m", 32'(dout_m), 32'h0ABC);
        check("lb_dout_l", 32'(dout_l), 32'h0ABC);
`endif

        for (int n = 0; n < 30; n++) begin
            run_frame(int'($urandom_range(0, 20)), WIDTH'($urandom), WIDTH'($urandom),
                      bit'($urandom_range(0, 1)),
`ifdef SPI_FRAME_SHIFTER_LOOPBACK_EN
                      bit'($urandom_range(0, 1))
`else
                      1'b0
`endif
                      );
            repeat ($urandom_range(0, 2)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
